pipeline_hazard_ctrl: RTL and testbench

Pipeline control block that consumes what the ID/EXE stage register presents (destination register, write/load flags, branch/jump flags) and drives the feedback path back into IF/ID. It keeps its own shadow copy of the destination information for the EXE, MEM and WB slots. From those slots it produces load-use stalls, taken-branch flushes, a bubble request for the ID/EXE register, and operand-forwarding selects for the EXE ALU inputs. Two saturating counters record stall and flush activity for debug.

---
 rtl/cpu_pipe_pkg.sv | 42 ++++
 rtl/sat_counter.sv | 18 +
 rtl/pipeline_hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline-control types: forwarding-select encodings and the
// destination-register shadow slot carried alongside EXE/MEM/WB.
package cpu_pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EXE = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef struct packed {
    logic [4:0] rn;
    logic       wreg;
    logic       m2reg;
  } slot_t;

  // $0 is hardwired, so a write to it never produces a hazard.
  function automatic logic slot_live(input slot_t s);
    return s.wreg && (s.rn != 5'd0);
  endfunction

  function automatic logic slot_match(input slot_t s, input logic [4:0] src);
    return slot_live(s) && (s.rn == src);
  endfunction

  function automatic logic slot_used(input slot_t s,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic urs, input logic urt);
    return (urs && slot_match(s, rs)) || (urt && slot_match(s, rt));
  endfunction

  // Nearest producer wins: MEM-slot result is the youngest value.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic uses,
                                         input slot_t s_mem, input slot_t s_wb,
                                         input slot_t s_wb2);
    if (!uses)                    return FWD_RF;
    else if (slot_match(s_mem, src)) return FWD_EXE;
    else if (slot_match(s_wb, src))  return FWD_MEM;
    else if (slot_match(s_wb2, src)) return FWD_WB;
    else                          return FWD_RF;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for debug event counts; sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (inc && !(&cnt))
      cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding control: tracks destination info of EXE..WB+1, raises
// load-use stalls and taken-branch flushes, and picks EXE operand sources.
module pipeline_hazard_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       id_rn,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic             exe_is_beq,
  input  logic             exe_is_bne,
  input  logic             exe_is_jump,
  input  logic             exe_z,
  output logic             pc_wen,
  output logic             ifid_wen,
  output logic             ifid_flush,
  output logic             idexe_bubble,
  output logic             branch_taken,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  slot_t      s_exe, s_mem, s_wb, s_wb2;
  logic [4:0] exe_rs, exe_rt;
  logic       exe_uses_rs, exe_uses_rt;

  logic take, stall, stall_exe, stall_mem;

  assign take      = exe_is_jump | (exe_is_beq & exe_z) | (exe_is_bne & ~exe_z);
  assign stall_exe = s_exe.m2reg && slot_used(s_exe, id_rs, id_rt, id_uses_rs, id_uses_rt);

  // A two-cycle load still has its data in flight while it sits in MEM.
  generate
    if (LOAD_LAT >= 2) begin : g_lat2
      assign stall_mem = s_mem.m2reg && slot_used(s_mem, id_rs, id_rt, id_uses_rs, id_uses_rt);
    end else begin : g_lat1
      assign stall_mem = 1'b0;
    end
  endgenerate

  assign stall = stall_exe | stall_mem;

  always_comb begin
    pc_wen       = 1'b1;
    ifid_wen     = 1'b1;
    ifid_flush   = 1'b0;
    idexe_bubble = 1'b0;
    branch_taken = 1'b0;
    if (rst) begin
      pc_wen       = 1'b0;
      ifid_wen     = 1'b0;
      idexe_bubble = 1'b1;
    end else if (take) begin
      branch_taken = 1'b1;
      ifid_flush   = 1'b1;
      idexe_bubble = 1'b1;
    end else if (stall) begin
      pc_wen       = 1'b0;
      ifid_wen     = 1'b0;
      idexe_bubble = 1'b1;
    end
  end

  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (!rst) begin
      fwd_a = fwd_sel(exe_rs, exe_uses_rs, s_mem, s_wb, s_wb2);
      fwd_b = fwd_sel(exe_rt, exe_uses_rt, s_mem, s_wb, s_wb2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_exe       <= '0;
      s_mem       <= '0;
      s_wb        <= '0;
      s_wb2       <= '0;
      exe_rs      <= '0;
      exe_rt      <= '0;
      exe_uses_rs <= 1'b0;
      exe_uses_rt <= 1'b0;
    end else begin
      s_wb2 <= s_wb;
      s_wb  <= s_mem;
      s_mem <= s_exe;
      if (idexe_bubble) begin
        s_exe       <= '0;
        exe_rs      <= '0;
        exe_rt      <= '0;
        exe_uses_rs <= 1'b0;
        exe_uses_rt <= 1'b0;
      end else begin
        s_exe.rn    <= id_rn;
        s_exe.wreg  <= id_wreg;
        s_exe.m2reg <= id_m2reg;
        exe_rs      <= id_rs;
        exe_rt      <= id_rt;
        exe_uses_rs <= id_uses_rs;
        exe_uses_rt <= id_uses_rt;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall & ~take),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (take),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (LOAD_LAT=1 and 2) on shared
// stimulus; expected forwarding selects queued at issue and checked in EXE.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, id_rn;
  logic       id_uses_rs, id_uses_rt, id_wreg, id_m2reg;
  logic       exe_is_beq, exe_is_bne, exe_is_jump, exe_z;

  logic        pc_wen1, ifid_wen1, ifid_flush1, idexe_bubble1, branch_taken1;
  logic [1:0]  fwd_a1, fwd_b1;
  logic [15:0] stall_cnt1, flush_cnt1;
  logic        pc_wen2, ifid_wen2, ifid_flush2, idexe_bubble2, branch_taken2;
  logic [1:0]  fwd_a2, fwd_b2;
  logic [15:0] stall_cnt2, flush_cnt2;

  int vectors = 0;
  int miscompares = 0;

  typedef struct { logic [1:0] a; logic [1:0] b; } fexp_t;
  fexp_t q1[$];
  fexp_t q2[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.LOAD_LAT(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rn(id_rn),
    .id_wreg(id_wreg), .id_m2reg(id_m2reg), .exe_is_beq(exe_is_beq),
    .exe_is_bne(exe_is_bne), .exe_is_jump(exe_is_jump), .exe_z(exe_z),
    .pc_wen(pc_wen1), .ifid_wen(ifid_wen1), .ifid_flush(ifid_flush1),
    .idexe_bubble(idexe_bubble1), .branch_taken(branch_taken1),
    .fwd_a(fwd_a1), .fwd_b(fwd_b1), .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
  );

  pipeline_hazard_ctrl #(.LOAD_LAT(2), .CNT_W(16)) u2 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rn(id_rn),
    .id_wreg(id_wreg), .id_m2reg(id_m2reg), .exe_is_beq(exe_is_beq),
    .exe_is_bne(exe_is_bne), .exe_is_jump(exe_is_jump), .exe_z(exe_z),
    .pc_wen(pc_wen2), .ifid_wen(ifid_wen2), .ifid_flush(ifid_flush2),
    .idexe_bubble(idexe_bubble2), .branch_taken(branch_taken2),
    .fwd_a(fwd_a2), .fwd_b(fwd_b2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  task automatic drive_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rn,
                          input logic urs, input logic urt, input logic w, input logic m);
    id_rs = rs; id_rt = rt; id_rn = rn;
    id_uses_rs = urs; id_uses_rt = urt; id_wreg = w; id_m2reg = m;
  endtask

  task automatic drive_nop();
    drive_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drive_br(input logic beq, input logic bne, input logic j, input logic z);
    exe_is_beq = beq; exe_is_bne = bne; exe_is_jump = j; exe_z = z;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; drive_nop(); drive_br(1'b0, 1'b0, 1'b0, 1'b0);
    next();
    rst = 1'b0;
    q1.delete(); q2.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; drive_nop(); drive_br(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if ({idexe_bubble1, pc_wen1, ifid_wen1, branch_taken1, ifid_flush1} !== 5'b10000) begin
        miscompares++;
        $display("FAIL reset_ctrl got=%b want=10000", {idexe_bubble1, pc_wen1, ifid_wen1, branch_taken1, ifid_flush1});
      end
      vectors++;
      if ({fwd_a1, fwd_b1, fwd_a2, fwd_b2} !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_fwd got=%h want=00", {fwd_a1, fwd_b1, fwd_a2, fwd_b2});
      end
      @(posedge clk); #1;
    end
    rst = 1'b0; drive_br(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    vectors++;
    if ({stall_cnt1, flush_cnt1, stall_cnt2, flush_cnt2} !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_cnt got=%h/%h/%h/%h want=0", stall_cnt1, flush_cnt1, stall_cnt2, flush_cnt2);
    end
    vectors++;
    if ({fwd_a1, fwd_b1, pc_wen1, idexe_bubble1} !== 6'b000010) begin
      miscompares++;
      $display("FAIL reset_release got=%b want=000010", {fwd_a1, fwd_b1, pc_wen1, idexe_bubble1});
    end
    next();
  endtask

  // Producer writes $3; consumer reads $3 (rs) and $5 (rt) after d NOPs.
  task automatic test_alu_dep(input int d);
    fexp_t e;
    do_reset();
    drive_id(5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    next();
    repeat (d) begin drive_nop(); next(); end
    drive_id(5'd3, 5'd5, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    e.a = 2'(d + 1); e.b = 2'd0;
    q1.push_back(e); q2.push_back(e);
    @(negedge clk);
    vectors++;
    if ({pc_wen1, pc_wen2, idexe_bubble1, idexe_bubble2} !== 4'b1100) begin
      miscompares++;
      $display("FAIL alu_dep%0d_nostall got=%b want=1100", d, {pc_wen1, pc_wen2, idexe_bubble1, idexe_bubble2});
    end
    next();
    drive_nop();
    @(negedge clk);
    e = q1.pop_front();
    vectors++;
    if ({fwd_a1, fwd_b1} !== {e.a, e.b}) begin
      miscompares++;
      $display("FAIL alu_dep%0d_fwd1 got=%0d/%0d want=%0d/%0d", d, fwd_a1, fwd_b1, e.a, e.b);
    end
    e = q2.pop_front();
    vectors++;
    if ({fwd_a2, fwd_b2, stall_cnt1, stall_cnt2} !== {e.a, e.b, 32'd0}) begin
      miscompares++;
      $display("FAIL alu_dep%0d_fwd2 got=%0d/%0d cnt=%0d/%0d want=%0d/%0d cnt=0/0",
               d, fwd_a2, fwd_b2, stall_cnt1, stall_cnt2, e.a, e.b);
    end
    next();
  endtask

  // lw $2 then add $6,$2,$2; ID holds the add until the slower instance releases it.
  task automatic test_load_use();
    fexp_t e;
    do_reset();
    drive_id(5'd0, 5'd0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    vectors++;
    if ({pc_wen1, pc_wen2} !== 2'b11) begin
      miscompares++;
      $display("FAIL lu_c0 got=%b want=11", {pc_wen1, pc_wen2});
    end
    next();
    drive_id(5'd2, 5'd2, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
    e.a = 2'd2; e.b = 2'd2; q1.push_back(e);
    e.a = 2'd3; e.b = 2'd3; q2.push_back(e);
    @(negedge clk);
    vectors++;
    if ({pc_wen1, ifid_wen1, idexe_bubble1, pc_wen2, ifid_wen2, idexe_bubble2} !== 6'b001001) begin
      miscompares++;
      $display("FAIL lu_c1_stall got=%b want=001001",
               {pc_wen1, ifid_wen1, idexe_bubble1, pc_wen2, ifid_wen2, idexe_bubble2});
    end
    next();
    @(negedge clk);
    vectors++;
    if ({pc_wen1, idexe_bubble1, pc_wen2, idexe_bubble2} !== 4'b1001) begin
      miscompares++;
      $display("FAIL lu_c2 got=%b want=1001", {pc_wen1, idexe_bubble1, pc_wen2, idexe_bubble2});
    end
    next();
    @(negedge clk);
    e = q1.pop_front();
    vectors++;
    if ({fwd_a1, fwd_b1} !== {e.a, e.b}) begin
      miscompares++;
      $display("FAIL lu_fwd1 got=%0d/%0d want=%0d/%0d", fwd_a1, fwd_b1, e.a, e.b);
    end
    vectors++;
    if ({pc_wen2, idexe_bubble2, stall_cnt1} !== {2'b10, 16'd1}) begin
      miscompares++;
      $display("FAIL lu_c3 got=%b cnt1=%0d want=10 cnt1=1", {pc_wen2, idexe_bubble2}, stall_cnt1);
    end
    next();
    drive_nop();
    @(negedge clk);
    e = q2.pop_front();
    vectors++;
    if ({fwd_a2, fwd_b2} !== {e.a, e.b}) begin
      miscompares++;
      $display("FAIL lu_fwd2 got=%0d/%0d want=%0d/%0d", fwd_a2, fwd_b2, e.a, e.b);
    end
    vectors++;
    if ({stall_cnt1, stall_cnt2} !== {16'd1, 16'd2}) begin
      miscompares++;
      $display("FAIL lu_cnt got=%0d/%0d want=1/2", stall_cnt1, stall_cnt2);
    end
    next();
  endtask

  task automatic test_zero_reg();
    fexp_t e;
    do_reset();
    drive_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    next();
    drive_id(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
    e.a = 2'd0; e.b = 2'd0; q1.push_back(e);
    @(negedge clk);
    vectors++;
    if ({pc_wen1, pc_wen2, idexe_bubble1, idexe_bubble2} !== 4'b1100) begin
      miscompares++;
      $display("FAIL zero_nostall got=%b want=1100", {pc_wen1, pc_wen2, idexe_bubble1, idexe_bubble2});
    end
    next();
    drive_nop();
    @(negedge clk);
    e = q1.pop_front();
    vectors++;
    if ({fwd_a1, fwd_b1, fwd_a2, fwd_b2} !== {e.a, e.b, e.a, e.b}) begin
      miscompares++;
      $display("FAIL zero_fwd got=%0d/%0d/%0d/%0d want=0", fwd_a1, fwd_b1, fwd_a2, fwd_b2);
    end
    next();
  endtask

  task automatic test_branch();
    logic [4:0] tbl [5];
    logic [4:0] v;
    logic [4:0] want;
    int fc;
    // {beq, bne, jump, z, expected take}
    tbl[0] = 5'b10011; tbl[1] = 5'b10000; tbl[2] = 5'b01001;
    tbl[3] = 5'b01010; tbl[4] = 5'b00101;
    fc = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      v = tbl[i];
      drive_br(v[4], v[3], v[2], v[1]);
      want = v[0] ? 5'b11111 : 5'b00011;
      if (v[0]) fc++;
      @(negedge clk);
      vectors++;
      if ({branch_taken1, ifid_flush1, idexe_bubble1, pc_wen1, ifid_wen1} !== want) begin
        miscompares++;
        $display("FAIL branch%0d got=%b want=%b", i,
                 {branch_taken1, ifid_flush1, idexe_bubble1, pc_wen1, ifid_wen1}, want);
      end
      next();
      drive_br(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      vectors++;
      if ({branch_taken1, ifid_flush1} !== 2'b00 || flush_cnt1 !== 16'(fc)) begin
        miscompares++;
        $display("FAIL branch%0d_after got=%b cnt=%0d want=00 cnt=%0d", i,
                 {branch_taken1, ifid_flush1}, flush_cnt1, fc);
      end
      next();
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    drive_id(5'd0, 5'd0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    next();
    drive_id(5'd2, 5'd2, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
    drive_br(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    vectors++;
    if ({pc_wen1, ifid_wen1, ifid_flush1, idexe_bubble1, branch_taken1} !== 5'b11111) begin
      miscompares++;
      $display("FAIL simul_ctrl got=%b want=11111",
               {pc_wen1, ifid_wen1, ifid_flush1, idexe_bubble1, branch_taken1});
    end
    next();
    drive_nop(); drive_br(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    vectors++;
    if ({stall_cnt1, flush_cnt1, stall_cnt2} !== {16'd0, 16'd1, 16'd0}) begin
      miscompares++;
      $display("FAIL simul_cnt got=%0d/%0d/%0d want=0/1/0", stall_cnt1, flush_cnt1, stall_cnt2);
    end
    next();
  endtask

  task automatic test_saturation();
    do_reset();
    drive_br(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (16'hFFFE) @(posedge clk);
    #1;
    vectors++;
    if (flush_cnt1 !== 16'hFFFE) begin
      miscompares++;
      $display("FAIL sat_preload got=%h want=fffe", flush_cnt1);
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({flush_cnt1, flush_cnt2} !== {16'hFFFF, 16'hFFFF}) begin
      miscompares++;
      $display("FAIL sat_hold got=%h/%h want=ffff", flush_cnt1, flush_cnt2);
    end
    // Reset with the jump still asserted must discard everything.
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({branch_taken1, ifid_flush1, pc_wen1, idexe_bubble1} !== 4'b0001) begin
      miscompares++;
      $display("FAIL rst_mid_ctrl got=%b want=0001", {branch_taken1, ifid_flush1, pc_wen1, idexe_bubble1});
    end
    next();
    rst = 1'b0; drive_br(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    vectors++;
    if ({flush_cnt1, flush_cnt2} !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_mid_cnt got=%h/%h want=0", flush_cnt1, flush_cnt2);
    end
    next();
  endtask

  initial begin
    rst = 1'b1;
    drive_nop();
    drive_br(1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_alu_dep(0);
    test_alu_dep(1);
    test_alu_dep(2);
    test_load_use();
    test_zero_reg();
    test_branch();
    test_simultaneous();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
